usb_packet_tx: RTL

- Transmit-side companion to the USB proxy receiver.
- Serializes one low-/full-speed USB packet onto a D+/D- pair: SYNC, PID, payload bytes, optional CRC16, then EOP.
- Applies NRZI encoding and bit stuffing.
- Used by the proxy to inject locally generated handshakes and data packets (ACK/NAK/DATAx) toward host or device.

---
 rtl/usb_packet_tx.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/usb_packet_tx.sv
// Serializes one LS/FS USB packet (SYNC, PID, payload, EOP) onto D+/D- with NRZI and bit stuffing.
// Define USB_TX_CRC16_EN to append a CRC16 after data PIDs (pid[1:0] == 2'b11).
module usb_packet_tx #(
  parameter int unsigned FS_DIV    = 4,
  parameter int unsigned LS_DIV    = 32,
  parameter int unsigned MAX_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   is_fs,
  input  logic                   start,
  input  logic [7:0]             pid,
  input  logic [3:0]             len,
  input  logic [8*MAX_BYTES-1:0] data,
  output logic                   busy,
  output logic                   done,
  output logic                   tx_oe,
  output logic                   tx_dp,
  output logic                   tx_dm
);

  localparam int unsigned DATA_W = 8 * MAX_BYTES;
  localparam int unsigned IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned DIV_W  = $clog2(((FS_DIV > LS_DIV) ? FS_DIV : LS_DIV) + 1);
  localparam int unsigned CNT_W  = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
`ifdef USB_TX_CRC16_EN
    S_CRC,
`endif
    S_EOP_SE0,
    S_EOP_J,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic [2:0]          ones_q, ones_d;
  logic                stuff_q, stuff_d;
  logic                level_q, level_d;   // 1 = J, 0 = K
  logic                se0_q, se0_d;
  logic                fs_q, fs_d;
  logic [7:0]          pid_q, pid_d;
  logic [3:0]          len_q, len_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tx_oe_q, tx_oe_d;
  logic                tx_dp_q, tx_dp_d;
  logic                tx_dm_q, tx_dm_d;
`ifdef USB_TX_CRC16_EN
  logic [15:0]         crc_q, crc_d;

  // Reflected CRC16 (x^16+x^15+x^2+1), one payload bit per call in transmit order
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    crc16_step = {1'b0, c[15:1]} ^ ((c[0] ^ b) ? 16'hA001 : 16'h0000);
  endfunction
`endif

  state_t              ns, after_data;
  logic [CNT_W-1:0]    nb;
  logic                nbit;
  logic                cur_is_bit;
  logic [DIV_W-1:0]    div_last;
  logic [3:0]          len_clamp;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    ones_d     = ones_q;
    stuff_d    = stuff_q;
    level_d    = level_q;
    se0_d      = se0_q;
    fs_d       = fs_q;
    pid_d      = pid_q;
    len_d      = len_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_oe_d    = tx_oe_q;
`ifdef USB_TX_CRC16_EN
    crc_d      = crc_q;
    after_data = (pid_q[1:0] == 2'b11) ? S_CRC : S_EOP_SE0;
`else
    after_data = S_EOP_SE0;
`endif
    div_last   = fs_q ? DIV_W'(FS_DIV - 1) : DIV_W'(LS_DIV - 1);
    len_clamp  = (32'(len) > MAX_BYTES) ? 4'(MAX_BYTES) : len;
    cur_is_bit = (state_q == S_SYNC) || (state_q == S_PID) || (state_q == S_DATA)
`ifdef USB_TX_CRC16_EN
                 || (state_q == S_CRC)
`endif
                 ;

    // Position of the symbol following the current (non-stuff) bit
    ns = state_q;
    nb = bit_q + CNT_W'(1);
    case (state_q)
      S_SYNC:    if (nb == CNT_W'(8)) begin ns = S_PID; nb = '0; end
      S_PID:     if (nb == CNT_W'(8)) begin ns = (len_q != 4'd0) ? S_DATA : after_data; nb = '0; end
      S_DATA:    if (nb == {len_q, 3'b000}) begin ns = after_data; nb = '0; end
`ifdef USB_TX_CRC16_EN
      S_CRC:     if (nb == CNT_W'(16)) begin ns = S_EOP_SE0; nb = '0; end
`endif
      S_EOP_SE0: if (nb == CNT_W'(2)) begin ns = S_EOP_J; nb = '0; end
      S_EOP_J:   begin ns = S_DONE; nb = '0; end
      default:   ;
    endcase

    case (ns)
      S_SYNC:  nbit = (nb == CNT_W'(7));
      S_PID:   nbit = pid_q[nb[2:0]];
      S_DATA:  nbit = data_q[nb[IDX_W-1:0]];
`ifdef USB_TX_CRC16_EN
      S_CRC:   nbit = ~crc_q[nb[3:0]];
`endif
      default: nbit = 1'b0;
    endcase

    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_SYNC;
        div_d   = '0;
        bit_d   = '0;
        ones_d  = '0;
        stuff_d = 1'b0;
        level_d = 1'b0;            // first SYNC bit is 0: J -> K
        se0_d   = 1'b0;
        fs_d    = is_fs;
        pid_d   = pid;
        len_d   = len_clamp;
        data_d  = data;
        busy_d  = 1'b1;
        tx_oe_d = 1'b1;
`ifdef USB_TX_CRC16_EN
        crc_d   = 16'hFFFF;
`endif
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else if (div_q != div_last) begin
      div_d = div_q + DIV_W'(1);
    end else begin
      div_d = '0;
      if (cur_is_bit && !stuff_q && (ones_q == 3'd6)) begin
        stuff_d = 1'b1;
        ones_d  = '0;
        level_d = ~level_q;
      end else begin
        stuff_d = 1'b0;
        state_d = ns;
        bit_d   = nb;
        case (ns)
          S_EOP_SE0: se0_d = 1'b1;
          S_EOP_J:   begin se0_d = 1'b0; level_d = 1'b1; end
          S_DONE:    begin tx_oe_d = 1'b0; done_d = 1'b1; level_d = 1'b1; end
          default: begin
            level_d = nbit ? level_q : ~level_q;
            ones_d  = nbit ? ones_q + 3'd1 : 3'd0;
          end
        endcase
`ifdef USB_TX_CRC16_EN
        if (ns == S_DATA) crc_d = crc16_step(crc_q, nbit);
`endif
      end
    end

    tx_dp_d = ~se0_d & ~(level_d ^ fs_d);
    tx_dm_d = ~se0_d &  (level_d ^ fs_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      ones_q  <= '0;
      stuff_q <= 1'b0;
      level_q <= 1'b1;
      se0_q   <= 1'b0;
      fs_q    <= 1'b1;
      pid_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_oe_q <= 1'b0;
      tx_dp_q <= 1'b1;
      tx_dm_q <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_q   <= 16'hFFFF;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      ones_q  <= ones_d;
      stuff_q <= stuff_d;
      level_q <= level_d;
      se0_q   <= se0_d;
      fs_q    <= fs_d;
      pid_q   <= pid_d;
      len_q   <= len_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_oe_q <= tx_oe_d;
      tx_dp_q <= tx_dp_d;
      tx_dm_q <= tx_dm_d;
`ifdef USB_TX_CRC16_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign tx_oe = tx_oe_q;
  assign tx_dp = tx_dp_q;
  assign tx_dm = tx_dm_q;

endmodule
